// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the cache arbiter
// Purpose: FSM state and grant-source enums used by cache_arbiter and arb_grant_sel.
// Ports: none (package).
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RECOVER
  } arb_state_t;

  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_src_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - I-cache / D-cache / physical-memory bus bundle
// Purpose: groups every cache-side and memory-side signal of the arbiter.
// Ports (modport slave = arbiter view, master = environment view):
//   icache_read, icache_address          I-cache fill request
//   icache_rdata, icache_resp            I-cache fill data / completion pulse
//   dcache_read, dcache_write            D-cache fill / writeback request
//   dcache_address, dcache_wdata         D-cache address / writeback data
//   dcache_rdata, dcache_resp            D-cache fill data / completion pulse
//   pmem_read, pmem_write                memory strobes
//   pmem_address, pmem_wdata             memory address / write data
//   pmem_rdata, pmem_resp                memory read data / completion pulse
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/arb_grant_sel.sv
// rtl/arb_grant_sel.sv - combinational I/D grant selection
// Purpose: picks which cache is granted from the current request pair.
// Config macro: ARB_ROUND_ROBIN_EN (defined: contention goes to the cache not in
//   last_grant; undefined: D-cache always wins contention, last_grant unused).
// Ports:
//   icache_req   in   I-cache request
//   dcache_req   in   D-cache request (read or write)
//   last_grant   in   source of the previous grant
//   grant        out  selected source
//   grant_valid  out  at least one request present
module arb_grant_sel
  import rv32i_types::*;
(
  input  logic     icache_req,
  input  logic     dcache_req,
  input  arb_src_t last_grant,
  output arb_src_t grant,
  output logic     grant_valid
);

  assign grant_valid = icache_req | dcache_req;

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = dcache_req ? ARB_D : ARB_I;
    if (icache_req && dcache_req) begin
      grant = (last_grant == ARB_D) ? ARB_I : ARB_D;
    end
  end
`else
  // History is irrelevant under fixed priority; sink it so it trims away.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == ARB_D);
  assign grant = dcache_req ? ARB_D : ARB_I;
`endif

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - I-cache / D-cache arbiter onto one physical-memory port
// Purpose: one memory transaction in flight; IDLE -> SERVE_x -> RECOVER -> IDLE.
// Config macro: ARB_ROUND_ROBIN_EN (selects round-robin contention in arb_grant_sel).
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    cache_arbiter_if.slave - cache requests/responses and memory port
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input logic            clk,
  input logic            rst_n,
  cache_arbiter_if.slave bus
);

  arb_state_t        state, state_next;
  arb_src_t          last_grant, grant;
  logic              grant_valid;
  logic              dcache_req;
  logic              op_write;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] irdata_q, drdata_q;
  logic              pmem_read_c, pmem_write_c;
  logic              icache_resp_c, dcache_resp_c;

  assign dcache_req = bus.dcache_read | bus.dcache_write;

  arb_grant_sel u_grant_sel (
    .icache_req  (bus.icache_read),
    .dcache_req  (dcache_req),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Strobes decode from state so an asynchronous reset drops them immediately.
  always_comb begin
    state_next    = state;
    pmem_read_c   = 1'b0;
    pmem_write_c  = 1'b0;
    icache_resp_c = 1'b0;
    dcache_resp_c = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) state_next = (grant == ARB_D) ? SERVE_D : SERVE_I;
      end
      SERVE_I: begin
        pmem_read_c = 1'b1;
        if (bus.pmem_resp) begin
          state_next    = RECOVER;
          // A requester that gave up still lets memory finish; its resp is dropped.
          icache_resp_c = bus.icache_read;
        end
      end
      SERVE_D: begin
        pmem_read_c  = ~op_write;
        pmem_write_c = op_write;
        if (bus.pmem_resp) begin
          state_next    = RECOVER;
          dcache_resp_c = dcache_req;
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ARB_I;
      op_write   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && grant_valid) begin
        last_grant <= grant;
        if (grant == ARB_D) begin
          addr_q   <= bus.dcache_address;
          wdata_q  <= bus.dcache_wdata;
          op_write <= bus.dcache_write;  // write wins if both ops are raised
        end else begin
          addr_q   <= bus.icache_address;
          op_write <= 1'b0;
        end
      end
      if (icache_resp_c) irdata_q <= bus.pmem_rdata;
      if (dcache_resp_c) drdata_q <= bus.pmem_rdata;
    end
  end

  assign bus.pmem_read    = pmem_read_c;
  assign bus.pmem_write   = pmem_write_c;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.icache_resp  = icache_resp_c;
  assign bus.dcache_resp  = dcache_resp_c;
  assign bus.icache_rdata = icache_resp_c ? bus.pmem_rdata : irdata_q;
  assign bus.dcache_rdata = dcache_resp_c ? bus.pmem_rdata : drdata_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.dcache_read && bus.dcache_write))
        else $error("cache_arbiter: dcache_read and dcache_write both high");
      assert (!((state == SERVE_I && !bus.icache_read) || (state == SERVE_D && !dcache_req)))
        else $error("cache_arbiter: request dropped before its resp");
      assert (!((state == IDLE || state == RECOVER) && bus.pmem_resp))
        else $error("cache_arbiter: pmem_resp with no transaction in flight");
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    bad++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [LW-1:0] ref_mem  [logic [AW-1:0]];
  logic [LW-1:0] phys_mem [logic [AW-1:0]];
  logic [LW-1:0] i_exp[$];
  logic [LW-1:0] d_exp[$];
  logic [AW-1:0] grant_log[$];

  function automatic logic [LW-1:0] init_line(logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (a * 32'h9E3779B1) + (k * 32'h01010101);
    return l;
  endfunction

  function automatic logic [LW-1:0] ref_get(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] phys_get(logic [AW-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  int            mem_lat  = 3;
  bit            rand_lat = 1'b0;
  int            cnt      = 0;
  int            cur_lat  = 1;
  int            rise_cyc = 0;
  logic [AW-1:0] cap_addr  = '0;
  logic [LW-1:0] cap_wdata = '0;
  logic          cap_write = 1'b0;

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
      total++;
      if ((bus.pmem_read & bus.pmem_write) !== 1'b0)
        fail("strobe_overlap", bus.pmem_read & bus.pmem_write, 1'b0);
      if (bus.pmem_read || bus.pmem_write) begin
        if (cnt == 0) begin
          cap_addr  = bus.pmem_address;
          cap_wdata = bus.pmem_wdata;
          cap_write = bus.pmem_write;
          rise_cyc  = cyc;
          grant_log.push_back(bus.pmem_address);
          cur_lat   = rand_lat ? int'($urandom_range(4, 1)) : mem_lat;
        end else begin
          total++;
          if (bus.pmem_address !== cap_addr) fail("addr_stable", bus.pmem_address, cap_addr);
          total++;
          if (bus.pmem_wdata !== cap_wdata) fail("wdata_stable", bus.pmem_wdata, cap_wdata);
          total++;
          if (bus.pmem_write !== cap_write) fail("write_stable", bus.pmem_write, cap_write);
          total++;
          if (bus.pmem_read !== ~cap_write) fail("read_stable", bus.pmem_read, ~cap_write);
        end
        cnt++;
        if (cnt >= cur_lat) begin
          if (cap_write) begin
            phys_mem[cap_addr] = cap_wdata;
            bus.pmem_rdata     = rand_line();
          end else begin
            bus.pmem_rdata = phys_get(cap_addr);
          end
          bus.pmem_resp = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  int n_iresp = 0;
  int n_dresp = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.icache_resp) n_iresp++;
      if (bus.dcache_resp) n_dresp++;
      total++;
      if ((bus.icache_resp & bus.dcache_resp) !== 1'b0)
        fail("resp_exclusive", bus.icache_resp & bus.dcache_resp, 1'b0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n_i = 0;
  int n_d = 0;
  int issue_cyc  = 0;
  int i_resp_cyc = 0;
  int d_resp_cyc = 0;

  task automatic txn(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    bit            got;
    logic [LW-1:0] e;
    @(posedge clk);
    #1;
    issue_cyc = cyc;
    if (is_d) begin
      n_d++;
      bus.dcache_address = a;
      bus.dcache_wdata   = wd;
      if (wr) begin
        ref_mem[a]       = wd;
        bus.dcache_write = 1'b1;
      end else begin
        d_exp.push_back(ref_get(a));
        bus.dcache_read = 1'b1;
      end
    end else begin
      n_i++;
      i_exp.push_back(ref_get(a));
      bus.icache_address = a;
      bus.icache_read    = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = is_d ? bus.dcache_resp : bus.icache_resp;
    end
    if (is_d) begin
      total++;
      if (got !== 1'b1) fail("d_resp_seen", got, 1'b1);
      if (got) begin
        d_resp_cyc = cyc;
        if (!wr) begin
          e = d_exp.pop_front();
          total++;
          if (bus.dcache_rdata !== e) fail("d_rdata", bus.dcache_rdata, e);
        end
      end
    end else begin
      total++;
      if (got !== 1'b1) fail("i_resp_seen", got, 1'b1);
      if (got) begin
        i_resp_cyc = cyc;
        e = i_exp.pop_front();
        total++;
        if (bus.icache_rdata !== e) fail("i_rdata", bus.icache_rdata, e);
      end
    end
    @(posedge clk);
    #1;
    if (is_d) begin
      bus.dcache_read  = 1'b0;
      bus.dcache_write = 1'b0;
    end else begin
      bus.icache_read = 1'b0;
    end
  endtask

  logic [LW-1:0] a5_line;
  logic [LW-1:0] t5_line;
  logic [AW-1:0] exp_first, exp_second;
  bit            got5;

  initial begin
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    a5_line = {32{8'hA5}};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.pmem_read !== 1'b0) fail("rst_pmem_read", bus.pmem_read, 1'b0);
    total++;
    if (bus.pmem_write !== 1'b0) fail("rst_pmem_write", bus.pmem_write, 1'b0);
    total++;
    if (bus.pmem_address !== 32'h0) fail("rst_pmem_address", bus.pmem_address, 32'h0);
    total++;
    if (bus.pmem_wdata !== {LW{1'b0}}) fail("rst_pmem_wdata", bus.pmem_wdata, {LW{1'b0}});
    total++;
    if (bus.icache_resp !== 1'b0) fail("rst_icache_resp", bus.icache_resp, 1'b0);
    total++;
    if (bus.dcache_resp !== 1'b0) fail("rst_dcache_resp", bus.dcache_resp, 1'b0);
    total++;
    if (bus.icache_rdata !== {LW{1'b0}}) fail("rst_icache_rdata", bus.icache_rdata, {LW{1'b0}});
    total++;
    if (bus.dcache_rdata !== {LW{1'b0}}) fail("rst_dcache_rdata", bus.dcache_rdata, {LW{1'b0}});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    mem_lat = 5;
    txn(1'b0, 1'b0, 32'h60, '0);
    total++;
    if ((rise_cyc - issue_cyc) !== 1) fail("t1_strobe_latency", rise_cyc - issue_cyc, 1);
    total++;
    if ((i_resp_cyc - rise_cyc) !== 4) fail("t1_mem_latency", i_resp_cyc - rise_cyc, 4);
    total++;
    if (cap_addr !== 32'h60) fail("t1_addr", cap_addr, 32'h60);
    total++;
    if (cap_write !== 1'b0) fail("t1_op_read", cap_write, 1'b0);
    @(negedge clk);
    total++;
    if (bus.icache_resp !== 1'b0) fail("t1_recover_resp", bus.icache_resp, 1'b0);
    total++;
    if (bus.pmem_read !== 1'b0) fail("t1_recover_strobe", bus.pmem_read, 1'b0);
    @(negedge clk);
    total++;
    if (bus.pmem_read !== 1'b0) fail("t1_idle_strobe", bus.pmem_read, 1'b0);

    mem_lat = 3;
    txn(1'b1, 1'b1, 32'h80, a5_line);
    total++;
    if (cap_addr !== 32'h80) fail("t2_addr", cap_addr, 32'h80);
    total++;
    if (cap_write !== 1'b1) fail("t2_op_write", cap_write, 1'b1);
    total++;
    if (cap_wdata !== a5_line) fail("t2_wdata", cap_wdata, a5_line);

    exp_first  = RR ? 32'h100 : 32'h200;
    exp_second = RR ? 32'h200 : 32'h100;
    grant_log.delete();
    fork
      txn(1'b0, 1'b0, 32'h100, '0);
      txn(1'b1, 1'b0, 32'h200, '0);
    join
    total++;
    if (grant_log.size() !== 2) fail("t3_grants", grant_log.size(), 2);
    total++;
    if (grant_log[0] !== exp_first) fail("t3_first", grant_log[0], exp_first);
    total++;
    if (grant_log[1] !== exp_second) fail("t3_second", grant_log[1], exp_second);
    total++;
    if ((d_resp_cyc < i_resp_cyc) !== !RR) fail("t3_d_before_i", d_resp_cyc < i_resp_cyc, !RR);

    for (int r = 0; r < 2; r++) begin
      exp_first = RR ? (32'h140 + r * 32'h20) : (32'h240 + r * 32'h20);
      grant_log.delete();
      fork
        txn(1'b0, 1'b0, 32'h140 + r * 32'h20, '0);
        txn(1'b1, 1'b0, 32'h240 + r * 32'h20, '0);
      join
      total++;
      if (grant_log[0] !== exp_first) fail("b2b_first", grant_log[0], exp_first);
    end

    mem_lat = 50;
    t5_line = init_line(32'h777);
    @(posedge clk);
    #1;
    n_d++;
    ref_mem[32'h300]   = t5_line;
    bus.dcache_address = 32'h300;
    bus.dcache_wdata   = t5_line;
    bus.dcache_write   = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    total++;
    if (bus.pmem_write !== 1'b1) fail("t5_write_before_rst", bus.pmem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.pmem_write !== 1'b0) fail("t5_async_drop", bus.pmem_write, 1'b0);
    total++;
    if (bus.dcache_resp !== 1'b0) fail("t5_no_resp", bus.dcache_resp, 1'b0);
    repeat (2) begin
      @(negedge clk);
      total++;
      if (bus.dcache_resp !== 1'b0) fail("t5_no_resp_in_rst", bus.dcache_resp, 1'b0);
    end
    @(posedge clk);
    #1;
    mem_lat = 3;
    grant_log.delete();
    rst_n = 1'b1;
    got5 = 1'b0;
    for (int k = 0; k < 50 && !got5; k++) begin
      @(negedge clk);
      got5 = bus.dcache_resp;
    end
    total++;
    if (got5 !== 1'b1) fail("t5_regrant_resp", got5, 1'b1);
    total++;
    if (grant_log[0] !== 32'h300) fail("t5_regrant_addr", grant_log[0], 32'h300);
    @(posedge clk);
    #1;
    bus.dcache_write = 1'b0;

    rand_lat = 1'b1;
    fork
      begin
        for (int ki = 0; ki < 1000; ki++) begin
          repeat ($urandom_range(2, 0)) @(posedge clk);
          txn(1'b0, 1'b0, $urandom() & 32'h0000_FFE0, '0);
        end
      end
      begin
        for (int kd = 0; kd < 1000; kd++) begin
          repeat ($urandom_range(3, 1)) @(posedge clk);
          txn(1'b1, 1'($urandom_range(1, 0)), 32'h1000_0000 | ($urandom() & 32'h0000_03E0), rand_line());
        end
      end
    join

    repeat (3) @(negedge clk);
    total++;
    if (n_iresp !== n_i) fail("i_resp_count", n_iresp, n_i);
    total++;
    if (n_dresp !== n_d) fail("d_resp_count", n_dresp, n_d);
    total++;
    if ((i_exp.size() + d_exp.size()) !== 0) fail("scoreboard_empty", i_exp.size() + d_exp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
